// File: rtl/icache_assoc_pkg.sv
// Shared types for the set-associative instruction cache:
// controller state encoding and a geometry helper for the derived sizes.
package torrence_types;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESPOND,
        FLUSH
    } icache_state_e;

    typedef enum int {
        G_SETS,
        G_WORDS,
        G_OFF,
        G_IDX
    } icache_geom_e;

    function automatic int icache_geom(
        input icache_geom_e sel,
        input int           line_size,
        input int           cache_size,
        input int           xlen,
        input int           ways
    );
        int sets;
        sets = cache_size / (line_size * ways);
        case (sel)
            G_SETS:  return sets;
            G_WORDS: return (line_size * 8) / xlen;
            G_OFF:   return $clog2(line_size);
            G_IDX:   return $clog2(sets);
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/icache_assoc_way.sv
// One cache way: per-set tag, valid bit and line data, plus tag compare.
// Ports: rd_* combinational lookup (valid/hit/data), wr_* beat write,
// tag_* tag write that also sets valid, clr_* valid clear for one set.
module icache_assoc_way #(
    parameter int SETS  = 16,
    parameter int WORDS = 8,
    parameter int XLEN  = 32,
    parameter int TAG_W = 23,
    parameter int IDX_W = 4,
    parameter int WRD_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_set,
    input  logic [WRD_W-1:0] rd_word,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic             hit,
    output logic [XLEN-1:0]  rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_set,
    input  logic [WRD_W-1:0] wr_word,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             tag_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_set
);

    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [XLEN-1:0]  data_mem [SETS][WORDS];
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  valid_d;

    always_comb begin
        valid_d = valid_q;
        if (clr_en) valid_d[clr_set] = 1'b0;
        if (tag_en) valid_d[wr_set]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Storage arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en)  data_mem[wr_set][wr_word] <= wr_data;
        if (tag_en) tag_mem[wr_set]           <= wr_tag;
    end

    assign rd_valid = valid_q[rd_set];
    assign hit      = rd_valid && (tag_mem[rd_set] == rd_tag);
    assign rd_data  = data_mem[rd_set][rd_word];

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with burst refill,
// round-robin victim choice (invalid ways first) and sequenced flush.
// Ports: req_* fetch request, rsp_* one-cycle response pulse,
// hmem_req_* line fetch handshake, hmem_rsp_* refill beats (word 0 first),
// flush_req / flush_busy whole-cache invalidate.
module icache_assoc
    import torrence_types::*;
#(
    parameter int LINE_SIZE  = 32,
    parameter int CACHE_SIZE = 1024,
    parameter int XLEN       = 32,
    parameter int WAYS       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [XLEN-1:0] req_addr,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            hmem_req_valid,
    output logic [XLEN-1:0] hmem_req_addr,
    input  logic            hmem_req_ready,
    input  logic            hmem_rsp_valid,
    input  logic [XLEN-1:0] hmem_rsp_data,
    input  logic            flush_req,
    output logic            flush_busy
);

    localparam int SETS  = icache_geom(G_SETS, LINE_SIZE, CACHE_SIZE, XLEN, WAYS);
    localparam int WORDS = icache_geom(G_WORDS, LINE_SIZE, CACHE_SIZE, XLEN, WAYS);
    localparam int OFF   = icache_geom(G_OFF, LINE_SIZE, CACHE_SIZE, XLEN, WAYS);
    localparam int IDX   = icache_geom(G_IDX, LINE_SIZE, CACHE_SIZE, XLEN, WAYS);
    localparam int BOFF  = $clog2(XLEN / 8);
    localparam int TAG_W = XLEN - OFF - IDX;
    localparam int IDX_W = (IDX > 0) ? IDX : 1;
    localparam int WRD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [XLEN-1:0] LINE_MASK = XLEN'(LINE_SIZE - 1);
    localparam logic [XLEN-1:0] SET_MASK  = XLEN'(SETS - 1);
    localparam logic [XLEN-1:0] WORD_MASK = XLEN'(WORDS - 1);
    localparam logic [WRD_W-1:0] LAST_CNT = WRD_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    icache_state_e    state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [RR_W-1:0]  victim_q, victim_d;
    logic             vic_rr_q, vic_rr_d;
    logic [WRD_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] fset_q, fset_d;
    logic [RR_W-1:0]  rr_q [SETS];
    logic [RR_W-1:0]  rr_d [SETS];

    logic [IDX_W-1:0] set_idx;
    logic [WRD_W-1:0] word_idx;
    logic [TAG_W-1:0] tag_val;
    logic [WRD_W-1:0] wr_word;

    logic [WAYS-1:0]  hit_w;
    logic [WAYS-1:0]  vld_w;
    logic [XLEN-1:0]  data_w [WAYS];

    logic             hit;
    logic [XLEN-1:0]  hit_data;
    logic [RR_W-1:0]  vic_sel;
    logic             vic_rr;

    logic             wr_en;
    logic             tag_en;
    logic             clr_vic;
    logic             clr_all;
    logic [IDX_W-1:0] clr_set;

    assign set_idx  = IDX_W'((addr_q >> OFF) & SET_MASK);
    assign word_idx = WRD_W'((addr_q >> BOFF) & WORD_MASK);
    assign tag_val  = TAG_W'(addr_q >> (OFF + IDX));
    assign wr_word  = LAST_CNT - cnt_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic sel;
        assign sel = (victim_q == RR_W'(w));

        icache_assoc_way #(
            .SETS  (SETS),
            .WORDS (WORDS),
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .IDX_W (IDX_W),
            .WRD_W (WRD_W)
        ) u_way (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_set   (set_idx),
            .rd_word  (word_idx),
            .rd_tag   (tag_val),
            .rd_valid (vld_w[w]),
            .hit      (hit_w[w]),
            .rd_data  (data_w[w]),
            .wr_en    (wr_en && sel),
            .wr_set   (set_idx),
            .wr_word  (wr_word),
            .wr_data  (hmem_rsp_data),
            .tag_en   (tag_en && sel),
            .wr_tag   (tag_val),
            .clr_en   (clr_all || (clr_vic && sel)),
            .clr_set  (clr_set)
        );
    end

    // At most one way matches, so an OR of gated data is the read mux.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit      = hit | hit_w[w];
            hit_data = hit_data | (data_w[w] & {XLEN{hit_w[w]}});
        end
    end

    // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        vic_sel = rr_q[set_idx];
        vic_rr  = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld_w[w]) begin
                vic_sel = RR_W'(w);
                vic_rr  = 1'b0;
            end
        end
        if (WAYS == 1) vic_sel = '0;
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        victim_d       = victim_q;
        vic_rr_d       = vic_rr_q;
        cnt_d          = cnt_q;
        fset_d         = fset_q;
        rr_d           = rr_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        hmem_req_valid = 1'b0;
        flush_busy     = 1'b0;
        wr_en          = 1'b0;
        tag_en         = 1'b0;
        clr_vic        = 1'b0;
        clr_all        = 1'b0;
        clr_set        = set_idx;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    fset_d  = '0;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        addr_d  = req_addr;
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (hit) begin
                    rsp_valid = 1'b1;
                    state_d   = IDLE;
                    if (!flush_req) begin
                        req_ready = 1'b1;
                        if (req_valid) begin
                            addr_d  = req_addr;
                            state_d = LOOKUP;
                        end
                    end
                end else begin
                    victim_d = vic_sel;
                    vic_rr_d = vic_rr;
                    state_d  = MISS_REQ;
                end
            end
            MISS_REQ: begin
                hmem_req_valid = 1'b1;
                if (hmem_req_ready) begin
                    clr_vic = 1'b1;
                    cnt_d   = LAST_CNT;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (hmem_rsp_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        tag_en = 1'b1;
                        if (vic_rr_q) rr_d[set_idx] = rr_q[set_idx] + 1'b1;
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            FLUSH: begin
                flush_busy = 1'b1;
                clr_all    = 1'b1;
                clr_set    = fset_q;
                fset_d     = fset_q + 1'b1;
                if (fset_q == LAST_SET) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Ready stays low while reset is held.
        req_ready = req_ready & rst_n;
    end

    assign hmem_req_addr = hmem_req_valid ? (addr_q & ~LINE_MASK) : '0;
    assign rsp_data      = rsp_valid ? hit_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            vic_rr_q <= 1'b0;
            cnt_q    <= '0;
            fset_q   <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            vic_rr_q <= vic_rr_d;
            cnt_q    <= cnt_d;
            fset_q   <= fset_d;
            rr_q     <= rr_d;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed scoreboard bench for icache_assoc (2 ways, 16 sets, 8 words).
// Stimulus queues expected words; a negedge monitor checks every response.
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        hmem_req_valid;
    logic [31:0] hmem_req_addr;
    logic        hmem_req_ready = 1'b0;
    logic        hmem_rsp_valid = 1'b0;
    logic [31:0] hmem_rsp_data = '0;
    logic        flush_req = 1'b0;
    logic        flush_busy;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    icache_assoc #(
        .LINE_SIZE  (32),
        .CACHE_SIZE (1024),
        .XLEN       (32),
        .WAYS       (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .hmem_req_valid (hmem_req_valid),
        .hmem_req_addr  (hmem_req_addr),
        .hmem_req_ready (hmem_req_ready),
        .hmem_rsp_valid (hmem_rsp_valid),
        .hmem_rsp_data  (hmem_rsp_data),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL rsp_extra: got %h want none", rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_data !== mon_e) begin
                    nerr++;
                    $display("FAIL rsp_data: got %h want %h", rsp_data, mon_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) chk("req_ready_to", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic serve(input logic [31:0] la, input logic [31:0] base,
                         input bit stall, input int nbeats);
        int n = 0;
        while (!hmem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("hreq_valid", 32'(hmem_req_valid), 32'd1);
        chk("hreq_addr", hmem_req_addr, la);
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                step();
                chk("stall_valid", 32'(hmem_req_valid), 32'd1);
                chk("stall_addr", hmem_req_addr, la);
            end
        end
        hmem_req_ready = 1'b1;
        step();
        hmem_req_ready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            hmem_rsp_valid = 1'b1;
            hmem_rsp_data  = base + 32'(i);
            step();
            hmem_rsp_valid = 1'b0;
            hmem_rsp_data  = 32'hDEAD_BEEF;
            if (stall) repeat (i % 3 + 1) step();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        step();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                      input bit miss, input logic [31:0] base,
                      input bit stall);
        exp_q.push_back(exp);
        issue(a);
        if (miss) begin
            serve(a & ~32'h1F, base, stall, 8);
        end else begin
            chk("hit_lat", 32'(rsp_valid), 32'd1);
            chk("hit_nohreq", 32'(hmem_req_valid), 32'd0);
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;
        #3;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_hreq", 32'(hmem_req_valid), 32'd0);
        chk("rst_busy", 32'(flush_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(req_ready), 32'd1);

        // Cold miss then hit on the same line
        rd(32'h40, 32'hA0, 1, 32'hA0, 0);
        rd(32'h5C, 32'hA7, 0, 0, 0);

        // Back-to-back hits
        exp_q.push_back(32'hA0);
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA2);
        req_valid = 1'b1;
        req_addr  = 32'h40;
        step();
        chk("b2b_0", 32'(rsp_valid), 32'd1);
        req_addr = 32'h44;
        step();
        chk("b2b_1", 32'(rsp_valid), 32'd1);
        req_addr = 32'h48;
        step();
        chk("b2b_2", 32'(rsp_valid), 32'd1);
        req_valid = 1'b0;
        drain();

        // Flush: busy for exactly 16 cycles, ready low throughout
        flush_req = 1'b1;
        #1;
        chk("flush_ready", 32'(req_ready), 32'd0);
        step();
        flush_req = 1'b0;
        n   = 0;
        bad = 1'b0;
        while (flush_busy && n < 100) begin
            if (req_ready) bad = 1'b1;
            n++;
            step();
        end
        chk("flush_len", 32'(n), 32'd16);
        chk("flush_rdy_low", 32'(bad), 32'd0);
        rd(32'h40, 32'hB0, 1, 32'hB0, 0);

        // Associativity and round-robin in set 2
        rd(32'h044, 32'hB1, 0, 0, 0);
        rd(32'h240, 32'hC0, 1, 32'hC0, 0);
        rd(32'h044, 32'hB1, 0, 0, 0);
        rd(32'h244, 32'hC1, 0, 0, 0);
        rd(32'h440, 32'hD0, 1, 32'hD0, 0);
        rd(32'h248, 32'hC2, 0, 0, 0);
        rd(32'h040, 32'hE0, 1, 32'hE0, 0);
        rd(32'h444, 32'hD1, 0, 0, 0);
        rd(32'h240, 32'hF0, 1, 32'hF0, 0);

        // Request stall and gapped beats
        rd(32'h10C, 32'h13, 1, 32'h10, 1);
        rd(32'h11C, 32'h17, 0, 0, 0);
        rd(32'h100, 32'h10, 0, 0, 0);

        // Reset in the middle of a refill
        issue(32'h180);
        serve(32'h180, 32'h50, 0, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_hreq", 32'(hmem_req_valid), 32'd0);
        chk("mid_rst_haddr", hmem_req_addr, 32'd0);
        chk("mid_rst_busy", 32'(flush_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        rd(32'h180, 32'h60, 1, 32'h60, 0);
        rd(32'h040, 32'h70, 1, 32'h70, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised N-way set-associative, read-only instruction cache.
- Successor to the direct-mapped icache: adds configurable associativity, round-robin victim selection that prefers invalid ways, and a sequenced whole-cache flush.
- Sits between the fetch stage and higher memory. Refills one line per miss as a burst of XLEN-bit beats.

Parameters:
- LINE_SIZE, 32, bytes per line (power of 2, at least XLEN/8).
- CACHE_SIZE, 1024, total data bytes (power of 2).
- XLEN, 32, word width in bits.
- WAYS, 2, associativity (power of 2, at least 1).
- Derived: WORDS = LINE_SIZE*8/XLEN; SETS = CACHE_SIZE/(LINE_SIZE*WAYS), must be at least 1.
- Address split: OFF = log2(LINE_SIZE), IDX = log2(SETS), TAG = XLEN-OFF-IDX.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  fetch request
- req_addr  in  XLEN  byte address; bits below log2(XLEN/8) are ignored
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  one-cycle pulse with fetched word
- rsp_data  out  XLEN  fetched word
- hmem_req_valid  out  1  line fetch request
- hmem_req_addr  out  XLEN  line-aligned address (low OFF bits zero)
- hmem_req_ready  in  1  higher memory accepts request
- hmem_rsp_valid  in  1  refill beat valid
- hmem_rsp_data  in  XLEN  refill beat, word 0 first, ascending order
- flush_req  in  1  invalidate all lines
- flush_busy  out  1  flush in progress

Behaviour:
- Reset: all valid bits, round-robin pointers, and the FSM (to IDLE) are cleared asynchronously. Tag and data arrays are not reset. All outputs reset to 0.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND, FLUSH.
- IDLE:
  - req_ready=1 unless flush_req=1.
  - flush_req has priority: go to FLUSH with the set counter at 0.
  - On an accepted request, latch the address and go to LOOKUP.
- LOOKUP:
  - All ways of the indexed set are compared in parallel.
  - Hit (exactly one way valid with matching tag): rsp_valid=1 and rsp_data=word this cycle, so hit latency is 1 cycle after accept. req_ready=1 (unless flush_req), which allows back-to-back hits at one per cycle. The next state is LOOKUP if a new request is accepted, else IDLE.
  - Miss: req_ready=0, go to MISS_REQ.
- MISS_REQ:
  - hmem_req_valid=1 and hmem_req_addr={tag,index,0} are held stable until hmem_req_ready.
  - The victim way is fixed on entry: lowest-index invalid way if any, else rr_ptr[set].
  - Then go to REFILL with the beat counter at WORDS-1.
- REFILL:
  - Each hmem_rsp_valid writes the beat into the victim way at word (WORDS-1-counter), then decrements the counter.
  - On entry, the victim valid bit is cleared.
  - On the last beat, write the tag, set valid, and increment rr_ptr[set] modulo WAYS (only if the victim was chosen by rr_ptr). Then go to RESPOND.
  - hmem_rsp_valid outside REFILL is ignored.
- RESPOND: rsp_valid=1 with the requested word read from the array; req_ready=0; next state IDLE.
- FLUSH:
  - flush_busy=1 and req_ready=0.
  - Clears the valid bits of one set per cycle, from set 0 to SETS-1, so a flush takes exactly SETS cycles.
  - Then go to IDLE. flush_req during FLUSH is ignored.
  - flush_req during a miss is held off until IDLE, and must be held high by the requester.
- Reset mid-refill: the partial line stays invalid and hmem_req_valid drops immediately. Higher memory must tolerate an abandoned burst.
- Widths: rr_ptr is max(1, log2 WAYS) bits and wraps naturally. With WAYS=1, the victim is always way 0.

Decomposition:
- Shared package (torrence_types) holds:
  - icache_state_e enum.
  - A function deriving SETS/WORDS/OFF/IDX.
- Sub-module icache_assoc_way: one way's tag, valid, and data storage with hit compare. Generated WAYS times, with write-enable and valid-clear inputs.
- The FSM, victim selection, and counters live in the top.

Test Plan (defaults: SETS=16, WORDS=8, index=addr[8:5]):
1. Cold miss and hit:
   - Read 0x40 -> hmem_req_addr=0x40; 8 beats 0xA0..0xA7 -> rsp_data=0xA0 in RESPOND.
   - Then read 0x5C -> hit, rsp_data=0xA7 one cycle after accept, no hmem_req_valid.
2. Associativity and round-robin:
   - Miss-fill 0x040, 0x240 (both set 2, fill ways 0, 1). Both then hit.
   - Read 0x440 -> evicts way 0 (rr_ptr=0). Then 0x040 misses, 0x240 still hits, 0x040 refills into way 1.
3. Back-to-back hits: req_valid held over addresses 0x40, 0x44, 0x48 -> three consecutive rsp_valid cycles with matching words.
4. Flush:
   - After test 1, pulse flush_req in IDLE -> flush_busy high exactly 16 cycles, req_ready=0.
   - Re-read 0x40 -> miss.
5. Handshake stall: hold hmem_req_ready=0 for 5 cycles -> hmem_req_valid/addr stable. Gaps between hmem_rsp_valid beats -> correct word placement.
6. Reset mid-refill: assert rst_n=0 after beat 3 -> all outputs 0 at once. Re-read the same address -> full miss, new data returned.
